// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - default geometry shared by the stream FIFO slice
package stream_fifo_pkg;

    // Default RAM address width (depth = 2**DEF_ASIZE) and data width.
    localparam int DEF_ASIZE = 3;
    localparam int DEF_DSIZE = 8;

endpackage

// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - valid/ready handshake bundle between producer, FIFO and consumer
interface stream_fifo_if
    import stream_fifo_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE,
    parameter int DSIZE = DEF_DSIZE
);
    logic             i_valid;
    logic [DSIZE-1:0] i_data;
    logic             o_ready;
    logic             o_valid;
    logic [DSIZE-1:0] o_data;
    logic             i_ready;
    logic [ASIZE:0]   o_level;

    // FIFO side: consumes the upstream word and the downstream ready.
    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_level
    );

    // Environment side: drives upstream words and downstream ready.
    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_level
    );
endinterface

// File: rtl/stream_fifo_dualram.sv
// rtl/stream_fifo_dualram.sv - storage array with one synchronous write port and one combinational read port
module dualram
    import stream_fifo_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE,
    parameter int DSIZE = DEF_DSIZE
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);
    logic [DSIZE-1:0] mem [0:(1<<ASIZE)-1];

    // Contents are deliberately not reset; pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - single-clock valid/ready FIFO with RAM storage and a registered head word
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int ASIZE = DEF_ASIZE,
    parameter int DSIZE = DEF_DSIZE
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    stream_fifo_if.slave bus
);
    localparam logic [ASIZE:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ASIZE:0]   wr_ptr;
    logic [ASIZE:0]   rd_ptr;
    logic             out_valid;
    logic [DSIZE-1:0] out_data;
    logic [DSIZE-1:0] ram_rdata;
    logic             ram_empty;
    logic             ram_full;
    logic             accept;
    logic             load;

    assign ram_empty = (wr_ptr == rd_ptr);
    assign ram_full  = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) &&
                       (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]);

    // Ready comes only from registered pointers, so a same-cycle load never frees a slot early.
    assign accept = bus.i_valid & ~ram_full;
    assign load   = ~ram_empty & (~out_valid | bus.i_ready);

    dualram #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (accept),
        .i_waddr (wr_ptr[ASIZE-1:0]),
        .i_wdata (bus.i_data),
        .i_raddr (rd_ptr[ASIZE-1:0]),
        .o_rdata (ram_rdata)
    );

    // Pointer advance; flush outranks any handshake in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (load) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Output register: refill from RAM when empty or consumed, drop valid when consumed with nothing behind it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (i_clr) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ram_rdata;
        end else if (out_valid && bus.i_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.o_ready = ~ram_full;
    assign bus.o_valid = out_valid;
    assign bus.o_data  = out_data;
    assign bus.o_level = (wr_ptr - rd_ptr) + {{ASIZE{1'b0}}, out_valid};
endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - self-checking bench for stream_fifo against a queue-based reference
module tb_stream_fifo;
    localparam int ASIZE = 3;
    localparam int DSIZE = 8;
    localparam int DEPTH = 1 << ASIZE;

    logic i_clk;
    logic i_rst_n;
    logic i_clr;

    stream_fifo_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus ();

    stream_fifo #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_clr),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int ncomp = 0;
    int nfail = 0;

    // Reference: words sitting in RAM, plus the head register.
    logic [7:0] m_ram [$];
    bit         m_ov;
    logic [7:0] m_od;

    logic [7:0] src_data;
    bit         rand_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ram.delete();
        m_ov = 1'b0;
        m_od = 8'h00;
    endtask

    task automatic check_model();
        chk("o_valid", 32'(bus.o_valid), 32'(m_ov));
        chk("o_ready", 32'(bus.o_ready), 32'(m_ram.size() < DEPTH));
        chk("o_level", 32'(bus.o_level), 32'(m_ram.size() + int'(m_ov)));
        chk("o_data", 32'(bus.o_data), 32'(m_od));
        chk("level_max", 32'(bus.o_level <= 9), 32'd1);
    endtask

    // One clock cycle: drive, check pre-edge state, advance model, land on the next negedge.
    task automatic cycle(input bit v, input bit r, input bit c);
        bit         acc;
        bit         ld;
        logic [7:0] d;
        bus.i_valid = v;
        bus.i_data  = src_data;
        bus.i_ready = r;
        i_clr       = c;
        #1;
        check_model();
        d = src_data;
        if (v && bus.o_ready && !c) begin
            src_data = rand_mode ? 8'($urandom) : src_data + 8'd1;
        end
        if (c) begin
            m_ram.delete();
            m_ov = 1'b0;
        end else begin
            acc = v && (m_ram.size() < DEPTH);
            ld  = (m_ram.size() > 0) && (!m_ov || r);
            if (ld) begin
                m_od = m_ram.pop_front();
                m_ov = 1'b1;
            end else if (m_ov && r) begin
                m_ov = 1'b0;
            end
            if (acc) m_ram.push_back(d);
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        bit         hold;
        logic [7:0] prev_od;
        logic [7:0] exp_out;
        bit         r;

        i_rst_n     = 1'b0;
        i_clr       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;
        src_data    = 8'h00;
        rand_mode   = 1'b0;
        model_reset();

        // Reset values.
        @(negedge i_clk);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_level", 32'(bus.o_level), 32'd0);
        chk("rst_data", 32'(bus.o_data), 32'd0);
        i_rst_n = 1'b1;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
        chk("idle_valid", 32'(bus.o_valid), 32'd0);
        chk("idle_ready", 32'(bus.o_ready), 32'd1);
        chk("idle_level", 32'(bus.o_level), 32'd0);

        // Single word: two-cycle latency, single-cycle presence.
        src_data = 8'hA5;
        cycle(1'b1, 1'b1, 1'b0);
        chk("single_c1_valid", 32'(bus.o_valid), 32'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("single_c2_valid", 32'(bus.o_valid), 32'd1);
        chk("single_c2_data", 32'(bus.o_data), 32'hA5);
        cycle(1'b0, 1'b1, 1'b0);
        chk("single_c3_valid", 32'(bus.o_valid), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);

        // Fill with a stalled consumer: 8 in RAM plus 1 in the head register.
        src_data = 8'h00;
        for (int i = 0; i < 12; i++) cycle(src_data <= 8'h09, 1'b0, 1'b0);
        chk("fill_accepted", 32'(src_data), 32'd9);
        chk("fill_ready", 32'(bus.o_ready), 32'd0);
        chk("fill_level", 32'(bus.o_level), 32'd9);
        exp_out = 8'h00;
        for (int i = 0; i < 14; i++) begin
            if (bus.o_valid) begin
                chk("drain_order", 32'(bus.o_data), 32'(exp_out));
                exp_out = exp_out + 8'd1;
            end
            cycle(src_data <= 8'h09, 1'b1, 1'b0);
        end
        chk("drain_count", 32'(exp_out), 32'd10);
        chk("drain_level", 32'(bus.o_level), 32'd0);

        // Streaming 100 words back to back across many pointer wraps.
        src_data = 8'h30;
        for (int i = 0; i < 102; i++) begin
            if (i >= 2) begin
                chk("stream_valid", 32'(bus.o_valid), 32'd1);
                chk("stream_data", 32'(bus.o_data), 32'(8'(8'h30 + i - 2)));
            end
            cycle(i < 100, 1'b1, 1'b0);
        end
        chk("stream_empty", 32'(bus.o_valid), 32'd0);

        // Random valid/ready with random data.
        rand_mode = 1'b1;
        src_data  = 8'($urandom);
        hold      = 1'b0;
        prev_od   = '0;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 99) < 45);
            if (hold) begin
                chk("hold_valid", 32'(bus.o_valid), 32'd1);
                chk("hold_data", 32'(bus.o_data), 32'(prev_od));
            end
            hold    = bus.o_valid && !r;
            prev_od = bus.o_data;
            cycle($urandom_range(0, 99) < 55, r, 1'b0);
        end
        rand_mode = 1'b0;

        // Flush with five words held and a write offered in the same cycle.
        cycle(1'b0, 1'b0, 1'b1);
        src_data = 8'h50;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("flush_pre_level", 32'(bus.o_level), 32'd5);
        cycle(1'b1, 1'b1, 1'b1);
        chk("flush_level", 32'(bus.o_level), 32'd0);
        chk("flush_valid", 32'(bus.o_valid), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("flush_dropped", 32'(bus.o_level), 32'd0);

        // Asynchronous reset in the middle of a stream.
        src_data = 8'h70;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_data", 32'(bus.o_data), 32'd0);
        chk("arst_level", 32'(bus.o_level), 32'd0);
        chk("arst_ready", 32'(bus.o_ready), 32'd1);
        model_reset();
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
